load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the execute stage. Consumes the execute result as the effective address.
//  Consumes rs2 as store data. Serves LB/LH/LW/LBU/LHU/SB/SH/SW and FLW/FSW (funct3=010 word path) over a
//  req/ready data-memory port. Returns an aligned, extended load value plus a one-cycle done pulse to the core FSM.
// PARAMETERS
//  ADDR_W          32   effective/memory address width
//  TIMEOUT_CYCLES  255  max REQ cycles without dmem_ready before abort (used only with LSU_TIMEOUT_EN)
// PORTS
//  clk          in   1       single core clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       core FSM launches an access (sampled in IDLE only)
//  mem_read     in   1       access is a load
//  mem_write    in   1       access is a store
//  funct3       in   3       access width/sign (RV32 encoding)
//  addr         in   ADDR_W  effective address (execute result)
//  store_data   in   32      rs2 / FP rs2 value
//  dmem_req     out  1       memory request, held until dmem_ready
//  dmem_we      out  1       1=write, 0=read; valid with dmem_req
//  dmem_addr    out  ADDR_W  word-aligned address (addr[1:0]=00)
//  dmem_wdata   out  32      store data replicated into byte lanes
//  dmem_wstrb   out  4       byte-enables; 0000 on reads
//  dmem_ready   in   1       memory accepts/completes the request this cycle
//  dmem_rdata   in   32      read word, valid when dmem_ready=1 on a read
//  load_data    out  32      extended load result; valid while done=1
//  done         out  1       one-cycle completion pulse
//  err_code     out  2       00 none, 01 misaligned, 10 illegal, 11 timeout; valid while done=1
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0. Reset asserted mid-access: dmem_req drops asynchronously; access abandoned; no done.
//  - FSM IDLE->REQ->DONE->IDLE. ERR path: IDLE->DONE with err_code!=00. No dmem_req is issued on the ERR path.
//  - IDLE with start=1: latch addr, funct3, store_data and direction.
//    - mem_read=mem_write=0: start is ignored; state stays IDLE.
//    - mem_read=mem_write=1: err 10.
//    - Load funct3 in {011,110,111}, or store funct3 not in {000,001,010}: err 10.
//    - Halfword with addr[0]=1, or word with addr[1:0]!=00: err 01.
//    - Otherwise: enter REQ.
//  - start is ignored outside IDLE.
//  - REQ: dmem_req=1. dmem_we/addr/wdata/wstrb are driven from latched registers and stay stable until the dmem_ready cycle.
//    - dmem_ready=1 in REQ: capture rdata on reads, then enter DONE.
//  - DONE: done=1 for exactly one cycle; err_code and load_data are held; then IDLE. A start in the DONE cycle is ignored.
//  - Latency: zero-wait memory gives done 2 cycles after the start cycle. Each wait cycle adds 1.
//  - Store lanes, off=addr[1:0]:
//    - SB: wstrb=0001<<off; wdata={4{sd[7:0]}}.
//    - SH: wstrb=0011<<off; wdata={2{sd[15:0]}}.
//    - SW: wstrb=1111; wdata=sd.
//  - Load extract: byte/half selected by off.
//    - LB/LH sign-extend; LBU/LHU zero-extend; LW/FLW pass through.
//    - load_data=0 on stores and on errors.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//    - A counter runs in REQ and clears on entry to REQ.
//    - After TIMEOUT_CYCLES consecutive REQ cycles with dmem_ready=0: req drops, state goes to DONE with err 11.
//    - dmem_ready in the same cycle as expiry wins (normal completion).
//  LSU_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; err 11 is never produced.
// STRUCTURE
//  - Package lsu_pkg holds:
//    - state encoding (IDLE/REQ/DONE);
//    - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
//    - err codes ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT.
//  - Sub-module lsu_load_align is combinational: (rdata, off, funct3) -> load_data.
// TESTING
//  - LW addr=0x100, store_data ignored, mem ready on first REQ cycle, rdata=0xDEADBEEF -> dmem_addr=0x100, wstrb=0000, done at start+2, load_data=0xDEADBEEF, err=00.
//  - LB addr=0x203, rdata=0x80FF_FF7F -> load_data=0xFFFFFF80. LBU at the same addr -> 0x00000080.
//  - SH addr=0x302, store_data=0x1234ABCD, ready after 3 wait cycles -> wdata=0xABCDABCD, wstrb=1100, req held 4 cycles with stable outputs, done at start+5.
//  - LW addr=0x101 -> no dmem_req, done at start+1 with err=01. Load funct3=011 -> err=10. Start with mem_read=mem_write=0 -> stays IDLE, no done.
//  - rst_n low during REQ (ready withheld) -> dmem_req=0 immediately, busy=0, no done. Next LW completes normally.
//  - LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted -> req high 4 cycles, then done with err=11, load_data=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 width codes,
// error codes and the request-legality helpers used by the IDLE decode.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    // funct3[1:0] carries the access size for every legal encoding (00 byte, 01 half, 10 word).
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extractor: selects the byte/halfword addressed by off from the
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: turns an execute-stage access into a req/ready data-memory transaction
// and returns an extended load value with a one-cycle done pulse. Optional REQ watchdog: LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       load_data,
    output logic              done,
    output logic [1:0]        err_code,
    output logic              busy
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       sd_q, sd_d;
    logic              we_q, we_d;
    logic [31:0]       load_data_q, load_data_d;
    logic [1:0]        err_q, err_d;

    logic [31:0]       aligned_data;
    logic [31:0]       lane_wdata;
    logic [3:0]        lane_wstrb;

    lsu_load_align u_align (
        .rdata     (dmem_rdata),
        .off       (addr_q[1:0]),
        .funct3    (f3_q),
        .load_data (aligned_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts REQ cycles already spent without dmem_ready; zero whenever not in REQ.
    assign cnt_d = (state_q == S_REQ) ? cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        sd_d        = sd_q;
        we_d        = we_q;
        load_data_d = load_data_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start && (mem_read || mem_write)) begin
                    addr_d      = addr;
                    f3_d        = funct3;
                    sd_d        = store_data;
                    we_d        = mem_write;
                    load_data_d = '0;
                    if ((mem_read && mem_write) ||
                        (mem_read && !load_f3_ok(funct3)) ||
                        (mem_write && !store_f3_ok(funct3))) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = S_DONE;
                    end else if (misaligned(funct3, addr[1:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_DONE;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_ready) begin
                    load_data_d = we_q ? 32'd0 : aligned_data;
                    state_d     = S_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    load_data_d = '0;
                    err_d       = ERR_TIMEOUT;
                    state_d     = S_DONE;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            f3_q        <= '0;
            sd_q        <= '0;
            we_q        <= 1'b0;
            load_data_q <= '0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            sd_q        <= sd_d;
            we_q        <= we_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                lane_wdata = {4{sd_q[7:0]}};
                lane_wstrb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                lane_wdata = {2{sd_q[15:0]}};
                lane_wstrb = 4'b0011 << addr_q[1:0];
            end
            default: begin
                lane_wdata = sd_q;
                lane_wstrb = 4'b1111;
            end
        endcase
    end

    // Bus outputs are qualified by REQ so they read zero in reset and between accesses.
    assign dmem_req   = (state_q == S_REQ);
    assign dmem_we    = dmem_req && we_q;
    assign dmem_addr  = dmem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wdata = dmem_we ? lane_wdata : 32'd0;
    assign dmem_wstrb = dmem_we ? lane_wstrb : 4'b0000;

    assign done      = (state_q == S_DONE);
    assign err_code  = done ? err_q : ERR_NONE;
    assign load_data = done ? load_data_q : 32'd0;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// checked against a spec-level reference model. Timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        done;
    logic [1:0]  err_code;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .load_data  (load_data),
        .done       (done),
        .err_code   (err_code),
        .busy       (busy)
    );

    // Reference model: derives the expected result straight from the access rules.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                                  output logic [1:0] e_err, output logic [31:0] e_ld,
                                  output logic [31:0] e_addr, output logic [31:0] e_wdata,
                                  output logic [3:0] e_wstrb);
        int off;
        int size;
        logic legal;
        logic [31:0] shifted;
        off     = int'(a % 4);
        e_addr  = a - 32'(off);
        e_wdata = 0;
        e_wstrb = 0;
        e_ld    = 0;
        if (rd && wr)  legal = 1'b0;
        else if (rd)   legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else           legal = (f3 inside {3'd0, 3'd1, 3'd2});
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        if (!legal)                    e_err = 2'b10;
        else if ((off % size) != 0)    e_err = 2'b01;
        else begin
            e_err = 2'b00;
            if (wr) begin
                if (size == 1) begin
                    e_wdata = sd[7:0] * 32'h0101_0101;
                    e_wstrb = 4'(1 << off);
                end else if (size == 2) begin
                    e_wdata = sd[15:0] * 32'h0001_0001;
                    e_wstrb = 4'(3 << off);
                end else begin
                    e_wdata = sd;
                    e_wstrb = 4'hF;
                end
            end else begin
                shifted = rdat >> (8 * off);
                if (size == 1) begin
                    e_ld = shifted & 32'hFF;
                    if (f3 == 3'd0 && e_ld >= 128) e_ld = e_ld + 32'hFFFF_FF00;
                end else if (size == 2) begin
                    e_ld = shifted & 32'hFFFF;
                    if (f3 == 3'd1 && e_ld >= 32768) e_ld = e_ld + 32'hFFFF_0000;
                end else begin
                    e_ld = rdat;
                end
            end
        end
    endfunction

    // Drives one access and a memory responder; reports what the DUT did. done_cyc counts
    // cycles after the start cycle (-1 if done never came within the budget).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input int waits,
                              input logic [31:0] rdat,
                              output int done_cyc, output int req_cyc, output logic stable,
                              output logic [31:0] ld, output logic [1:0] ec,
                              output logic [31:0] o_addr, output logic [31:0] o_wdata,
                              output logic [3:0] o_wstrb, output logic o_we, output logic post_ok);
        done_cyc = -1; req_cyc = 0; stable = 1'b1; ld = 0; ec = 0;
        o_addr = 0; o_wdata = 0; o_wstrb = 0; o_we = 0; post_ok = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        @(posedge clk); #1;
        start = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
        funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = n; ld = load_data; ec = err_code;
                dmem_ready = 1'b0;
                break;
            end
            if (dmem_req) begin
                if (req_cyc == 0) begin
                    o_addr = dmem_addr; o_wdata = dmem_wdata; o_wstrb = dmem_wstrb; o_we = dmem_we;
                end else if ({dmem_addr, dmem_wdata, dmem_wstrb, dmem_we} !==
                             {o_addr, o_wdata, o_wstrb, o_we}) begin
                    stable = 1'b0;
                end
                req_cyc++;
                dmem_ready = (req_cyc > waits);
                dmem_rdata = dmem_ready ? rdat : $urandom;
            end else begin
                dmem_ready = 1'b0;
            end
        end
        dmem_ready = 1'b0;
        if (done_cyc > 0) begin
            // A legal load offered during the DONE cycle must be ignored.
            start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h0;
            @(negedge clk);
            post_ok = !done && !busy && !dmem_req;
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({dmem_req, dmem_we, done, busy} !== 4'b0000)
            $display("FAIL reset_ctrl got req/we/done/busy=%b exp=0000", {dmem_req, dmem_we, done, busy});
        else pass_cnt++;
        total_cnt++;
        if ({dmem_addr, dmem_wdata, dmem_wstrb} !== 68'd0)
            $display("FAIL reset_bus got addr=%h wdata=%h wstrb=%b exp=0", dmem_addr, dmem_wdata, dmem_wstrb);
        else pass_cnt++;
        total_cnt++;
        if ({load_data, err_code} !== 34'd0)
            $display("FAIL reset_result got load_data=%h err=%b exp=0", load_data, err_code);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw_basic();
        int dc, rc; logic st, we, pk; logic [31:0] ld, oa, ow; logic [3:0] ws; logic [1:0] ec;
        run_access(1, 0, F3_W, 32'h100, $urandom, 0, 32'hDEAD_BEEF, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if (oa !== 32'h100) $display("FAIL lw_addr got=%h exp=00000100", oa); else pass_cnt++;
        total_cnt++;
        if ({we, ws} !== 5'b0) $display("FAIL lw_we_wstrb got we=%b wstrb=%b exp=0/0000", we, ws); else pass_cnt++;
        total_cnt++;
        if (dc !== 2) $display("FAIL lw_latency got=%0d exp=2", dc); else pass_cnt++;
        total_cnt++;
        if (ld !== 32'hDEAD_BEEF) $display("FAIL lw_data got=%h exp=deadbeef", ld); else pass_cnt++;
        total_cnt++;
        if (ec !== 2'b00) $display("FAIL lw_err got=%b exp=00", ec); else pass_cnt++;
        total_cnt++;
        if (pk !== 1'b1) $display("FAIL lw_done_pulse got post_ok=%b exp=1", pk); else pass_cnt++;
    endtask

    task automatic test_lb_lbu();
        int dc, rc; logic st, we, pk; logic [31:0] ld, oa, ow; logic [3:0] ws; logic [1:0] ec;
        run_access(1, 0, F3_B, 32'h203, 0, 0, 32'h80FF_FF7F, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if (ld !== 32'hFFFF_FF80) $display("FAIL lb_sext got=%h exp=ffffff80", ld); else pass_cnt++;
        total_cnt++;
        if (oa !== 32'h200) $display("FAIL lb_addr got=%h exp=00000200", oa); else pass_cnt++;
        run_access(1, 0, F3_BU, 32'h203, 0, 0, 32'h80FF_FF7F, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if (ld !== 32'h0000_0080) $display("FAIL lbu_zext got=%h exp=00000080", ld); else pass_cnt++;
    endtask

    task automatic test_sh_wait();
        int dc, rc; logic st, we, pk; logic [31:0] ld, oa, ow; logic [3:0] ws; logic [1:0] ec;
        run_access(0, 1, F3_H, 32'h302, 32'h1234_ABCD, 3, $urandom, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if (ow !== 32'hABCD_ABCD) $display("FAIL sh_wdata got=%h exp=abcdabcd", ow); else pass_cnt++;
        total_cnt++;
        if ({we, ws} !== 5'b1_1100) $display("FAIL sh_wstrb got we=%b wstrb=%b exp=1/1100", we, ws); else pass_cnt++;
        total_cnt++;
        if (rc !== 4) $display("FAIL sh_req_cycles got=%0d exp=4", rc); else pass_cnt++;
        total_cnt++;
        if (st !== 1'b1) $display("FAIL sh_stable got=%b exp=1", st); else pass_cnt++;
        total_cnt++;
        if (dc !== 5) $display("FAIL sh_latency got=%0d exp=5", dc); else pass_cnt++;
        total_cnt++;
        if ({ld, ec} !== 34'd0) $display("FAIL sh_result got load_data=%h err=%b exp=0/00", ld, ec); else pass_cnt++;
    endtask

    task automatic test_errors();
        int dc, rc; logic st, we, pk; logic [31:0] ld, oa, ow; logic [3:0] ws; logic [1:0] ec;
        logic seen;
        run_access(1, 0, F3_W, 32'h101, 0, 0, $urandom, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if (rc !== 0) $display("FAIL misalign_noreq got req_cycles=%0d exp=0", rc); else pass_cnt++;
        total_cnt++;
        if (dc !== 1) $display("FAIL misalign_latency got=%0d exp=1", dc); else pass_cnt++;
        total_cnt++;
        if (ec !== 2'b01) $display("FAIL misalign_err got=%b exp=01", ec); else pass_cnt++;
        run_access(1, 0, 3'b011, 32'h40, 0, 0, $urandom, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if ({ec, rc[3:0]} !== 6'b10_0000) $display("FAIL load_f3_011 got err=%b req_cycles=%0d exp=10/0", ec, rc); else pass_cnt++;
        run_access(1, 1, F3_W, 32'h40, 0, 0, $urandom, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if (ec !== 2'b10) $display("FAIL rd_and_wr got err=%b exp=10", ec); else pass_cnt++;
        run_access(0, 1, F3_BU, 32'h40, 0, 0, $urandom, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if (ec !== 2'b10) $display("FAIL store_f3_100 got err=%b exp=10", ec); else pass_cnt++;

        @(posedge clk); #1;
        start = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = F3_W; addr = 32'h80;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || dmem_req) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL no_op_start got activity=%b exp=0", seen); else pass_cnt++;
    endtask

    task automatic test_random();
        int dc, rc; logic st, we, pk; logic [31:0] ld, oa, ow; logic [3:0] ws; logic [1:0] ec;
        logic rd, wr; logic [2:0] f3; logic [31:0] a, sd, rdat;
        int waits, op;
        logic [1:0] e_err; logic [31:0] e_ld, e_addr, e_wdata; logic [3:0] e_wstrb;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 9));
            rd = (op < 5) || (op == 9);
            wr = (op >= 5);
            f3 = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : {a[1], 1'b0} & {1'b1, f3[1:0] == 2'b00};
            sd = $urandom; rdat = $urandom;
            waits = int'($urandom_range(0, 3));
            model(rd, wr, f3, a, sd, rdat, e_err, e_ld, e_addr, e_wdata, e_wstrb);
            run_access(rd, wr, f3, a, sd, waits, rdat, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
            total_cnt++;
            if (ec !== e_err) $display("FAIL rnd%0d_err got=%b exp=%b", i, ec, e_err); else pass_cnt++;
            total_cnt++;
            if (ld !== e_ld) $display("FAIL rnd%0d_load got=%h exp=%h", i, ld, e_ld); else pass_cnt++;
            total_cnt++;
            if (dc !== ((e_err == 2'b00) ? waits + 2 : 1))
                $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, dc, (e_err == 2'b00) ? waits + 2 : 1);
            else pass_cnt++;
            total_cnt++;
            if (rc !== ((e_err == 2'b00) ? waits + 1 : 0))
                $display("FAIL rnd%0d_req_cycles got=%0d exp=%0d", i, rc, (e_err == 2'b00) ? waits + 1 : 0);
            else pass_cnt++;
            if (e_err == 2'b00) begin
                total_cnt++;
                if ({oa, ws, we} !== {e_addr, e_wstrb, wr})
                    $display("FAIL rnd%0d_bus got addr=%h wstrb=%b we=%b exp=%h/%b/%b", i, oa, ws, we, e_addr, e_wstrb, wr);
                else pass_cnt++;
                total_cnt++;
                if (st !== 1'b1) $display("FAIL rnd%0d_stable got=%b exp=1", i, st); else pass_cnt++;
                if (wr) begin
                    total_cnt++;
                    if (ow !== e_wdata) $display("FAIL rnd%0d_wdata got=%h exp=%h", i, ow, e_wdata); else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int dc, rc; logic st, we, pk; logic [31:0] ld, oa, ow; logic [3:0] ws; logic [1:0] ec;
        logic seen;
        @(posedge clk); #1;
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h400;
        @(posedge clk); #1;
        start = 1'b0; mem_read = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (dmem_req !== 1'b1) $display("FAIL rstmid_req_before got=%b exp=1", dmem_req); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({dmem_req, busy} !== 2'b00) $display("FAIL rstmid_async got req/busy=%b exp=00", {dmem_req, busy}); else pass_cnt++;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL rstmid_no_done got=%b exp=0", seen); else pass_cnt++;
        run_access(1, 0, F3_W, 32'h404, 0, 1, 32'hCAFE_F00D, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if ({ld, ec} !== {32'hCAFE_F00D, 2'b00}) $display("FAIL rstmid_next_lw got=%h/%b exp=cafef00d/00", ld, ec); else pass_cnt++;
        total_cnt++;
        if (dc !== 3) $display("FAIL rstmid_next_latency got=%0d exp=3", dc); else pass_cnt++;
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int dc, rc; logic st, we, pk; logic [31:0] ld, oa, ow; logic [3:0] ws; logic [1:0] ec;
        run_access(1, 0, F3_W, 32'h500, 0, 1000, $urandom, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if (rc !== 4) $display("FAIL timeout_req_cycles got=%0d exp=4", rc); else pass_cnt++;
        total_cnt++;
        if (dc !== 5) $display("FAIL timeout_latency got=%0d exp=5", dc); else pass_cnt++;
        total_cnt++;
        if ({ec, ld} !== {2'b11, 32'd0}) $display("FAIL timeout_result got err=%b load_data=%h exp=11/0", ec, ld); else pass_cnt++;
        // Ready arriving on the expiry cycle completes normally.
        run_access(1, 0, F3_W, 32'h504, 0, 3, 32'h1357_9BDF, dc, rc, st, ld, ec, oa, ow, ws, we, pk);
        total_cnt++;
        if ({ec, ld} !== {2'b00, 32'h1357_9BDF}) $display("FAIL timeout_ready_wins got err=%b load_data=%h exp=00/13579bdf", ec, ld); else pass_cnt++;
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        dmem_ready = 1'b0; dmem_rdata = 32'd0;
        test_reset();
        test_lw_basic();
        test_lb_lbu();
        test_sh_wait();
        test_errors();
        test_random();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
